// File: rtl/matrix_stream_pack32x10.sv
// Streams signed elements into a flat row-major ROWS*COLS*DW matrix bus.
// The completed matrix is held with a valid/ready handshake until it is taken.
module matrix_stream_pack32x10 #(
  parameter int ROWS = 32,
  parameter int COLS = 10,
  parameter int DW   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [ROWS*COLS*DW-1:0]  mat_data,
  output logic                     mat_valid,
  input  logic                     mat_ready,
  output logic                     last_err
);

  localparam int N     = ROWS * COLS;
  localparam int TOTAL = N * DW;
  localparam int IW    = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          wr_en;
  logic          frame_err;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    mat_valid = 1'b0;
    wr_en     = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        // flush wins over an element offered in the same cycle
        if (flush) begin
          idx_nxt = '0;
        end else if (in_valid) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = FULL;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      FULL: begin
        mat_valid = 1'b1;
        if (flush || mat_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  assign frame_err = wr_en && (in_last != (idx == LAST_IDX));

  // NOTE: registered state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      idx      <= '0;
      last_err <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (frame_err) last_err <= 1'b1;
    end
  end

  // NOTE: the matrix storage is reset because an all-zero bus is a visible post-reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_data <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        if (idx == IW'(k)) mat_data[TOTAL-1-DW*k -: DW] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_pack32x10.sv
// Randomized self-checking bench for matrix_stream_pack32x10 with a slot-array
// reference model and per-cycle comparison of every output.
module tb_matrix_stream_pack32x10;

  localparam int ROWS  = 32;
  localparam int COLS  = 10;
  localparam int DW    = 32;
  localparam int N     = ROWS * COLS;
  localparam int TOTAL = N * DW;

  logic             clk, rst_n;
  logic [DW-1:0]    in_data;
  logic             in_valid, in_last, in_ready, flush;
  logic [TOTAL-1:0] mat_data;
  logic             mat_valid, mat_ready, last_err;

  int n_checks = 0;
  int n_pass   = 0;

  matrix_stream_pack32x10 #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .flush(flush),
    .mat_data(mat_data), .mat_valid(mat_valid), .mat_ready(mat_ready),
    .last_err(last_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] dut_slot(input int k);
    return mat_data[TOTAL-1-DW*k -: DW];
  endfunction

  // Reference model: matrix as an array of slots, a fill count and a held flag.
  logic [31:0] m_slot [N];
  int          m_cnt;
  logic        m_full, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_slot[k] <= '0;
      m_cnt  <= 0;
      m_full <= 1'b0;
      m_err  <= 1'b0;
    end else if (!m_full) begin
      if (flush) begin
        m_cnt <= 0;
      end else if (in_valid) begin
        m_slot[m_cnt] <= in_data;
        if (in_last != (m_cnt == N - 1)) m_err <= 1'b1;
        m_cnt  <= (m_cnt + 1) % N;
        m_full <= (m_cnt == N - 1);
      end
    end else if (flush || mat_ready) begin
      m_full <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int bad;
    bad = 0;
    check("in_ready",  32'(in_ready),  32'(!m_full));
    check("mat_valid", 32'(mat_valid), 32'(m_full));
    check("last_err",  32'(last_err),  32'(m_err));
    for (int k = N - 1; k >= 0; k--) if (dut_slot(k) !== m_slot[k]) bad = k;
    check("mat_data", dut_slot(bad), m_slot[bad]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input bit gaps);
    if (gaps) begin
      while ($urandom_range(1, 0) == 0) tick();
    end
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    check("take_valid", 32'(mat_valid), 32'd1);
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
    check("take_drop_valid", 32'(mat_valid), 32'd0);
    check("take_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(mat_valid), 32'd0);
    check("rst_err",   32'(last_err),  32'd0);
    check("rst_slot0", dut_slot(0),    32'd0);
    check("rst_slot199", dut_slot(199), 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  // Streams base+k for k=0..N-1, checking mat_valid is low until the 320th accept.
  task automatic stream_seq(input logic [31:0] base, input bit gaps);
    for (int k = 0; k < N; k++) begin
      send(base + 32'(k), k == N - 1, gaps);
      if (k == N - 2) check("valid_before_last", 32'(mat_valid), 32'd0);
    end
    check("valid_after_last", 32'(mat_valid), 32'd1);
  endtask

  logic [31:0] snap0, snap_end;

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    flush = 1'b0; mat_ready = 1'b0;
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: full sequential fill
    stream_seq(32'd1000, 1'b0);
    check("s1_slot00", dut_slot(0), 32'd1000);
    check("s1_slot319", mat_data[31:0], 32'd1319);
    check("s1_slot3_4", dut_slot(3 * COLS + 4), 32'd1034);
    check("s1_in_ready_full", 32'(in_ready), 32'd0);
    check("s1_last_err", 32'(last_err), 32'd0);

    // 2: hold, take, negative fill
    snap0 = dut_slot(0);
    snap_end = dut_slot(N - 1);
    repeat (5) tick();
    check("s2_hold_valid", 32'(mat_valid), 32'd1);
    check("s2_hold_slot0", dut_slot(0), snap0);
    check("s2_hold_slot319", dut_slot(N - 1), snap_end);
    take();
    for (int k = 0; k < N; k++) send(-32'(k + 1), k == N - 1, 1'b0);
    check("s2_slot00", dut_slot(0), 32'hFFFF_FFFF);
    check("s2_slot319", dut_slot(N - 1), -32'd320);
    take();

    // 3: random gaps, same matrix as scenario 1
    stream_seq(32'd1000, 1'b1);
    check("s3_slot00", dut_slot(0), 32'd1000);
    check("s3_slot319", dut_slot(N - 1), 32'd1319);
    check("s3_slot3_4", dut_slot(34), 32'd1034);
    take();

    // 4: framing error at idx 100
    for (int k = 0; k < N; k++) begin
      send(32'(k), (k == 100) || (k == N - 1), 1'b0);
      if (k == 99)  check("s4_err_before", 32'(last_err), 32'd0);
      if (k == 100) check("s4_err_set", 32'(last_err), 32'd1);
    end
    check("s4_complete", 32'(mat_valid), 32'd1);
    take();
    check("s4_err_sticky", 32'(last_err), 32'd1);

    // 5: partial fill, flush with a valid element, then full fill
    for (int k = 0; k < 50; k++) send(32'd5000 + 32'(k), 1'b0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'd9999;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    stream_seq(32'd7000, 1'b0);
    check("s5_slot00", dut_slot(0), 32'd7000);
    check("s5_slot50", dut_slot(50), 32'd7050);
    check("s5_slot319", dut_slot(N - 1), 32'd7319);
    check("s5_err_kept", 32'(last_err), 32'd1);
    take();

    // 6: async reset mid-fill and while full
    for (int k = 0; k < 200; k++) send($urandom, 1'b0, 1'b0);
    async_reset();
    for (int k = 0; k < N; k++) send($urandom, k == N - 1, 1'b0);
    check("s6_full", 32'(mat_valid), 32'd1);
    async_reset();
    send(32'hABCD_0001, 1'b0, 1'b0);
    check("s6_refill_slot0", dut_slot(0), 32'hABCD_0001);
    check("s6_refill_slot1", dut_slot(1), 32'd0);

    // random traffic with occasional flush, stray in_last and consumer stalls
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(9, 0) < 7);
      in_data   = $urandom;
      in_last   = ($urandom_range(99, 0) == 0);
      flush     = ($urandom_range(99, 0) < 2);
      mat_ready = ($urandom_range(9, 0) < 3);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; mat_ready = 1'b0; in_last = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
